// File: rtl/coherent_dcache.sv
// Direct-mapped, one-word-block, write-back L1 data cache with MSI coherence.
// Serves datapath loads/stores, answers snoops from the peer core and flushes dirty lines on halt.
module coherent_dcache #(
  parameter int SETS  = 16,
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 30 - IDXW;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SETS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WB       = 3'd1;
  localparam logic [2:0] FETCH    = 3'd2;
  localparam logic [2:0] SNOOP    = 3'd3;
  localparam logic [2:0] SNOOP_WB = 3'd4;
  localparam logic [2:0] FLUSH    = 3'd5;
  localparam logic [2:0] HALTED   = 3'd6;

  localparam logic [1:0] MSI_I = 2'd0;
  localparam logic [1:0] MSI_S = 2'd1;
  localparam logic [1:0] MSI_M = 2'd2;

  logic [2:0]      r_state;
  logic [2:0]      r_ret;
  logic [IDXW-1:0] r_fidx;
  logic [31:0]     r_snp_addr;
  logic            r_snp_inv;
  logic [TAGW-1:0] r_tag  [SETS];
  logic [31:0]     r_data [SETS];
  logic [1:0]      r_msi  [SETS];

  logic [IDXW-1:0] w_idx;
  logic [TAGW-1:0] w_tag;
  logic            w_req;
  logic            w_match;
  logic            w_rd_hit;
  logic            w_wr_hit;
  logic            w_victim_m;
  logic [IDXW-1:0] w_snp_idx;
  logic            w_snp_hit;
  logic [IDXW-1:0] w_sidx;
  logic            w_fl_m;
  logic            w_unused;

  assign w_idx      = dmemaddr[IDXW+1:2];
  assign w_tag      = dmemaddr[31:IDXW+2];
  assign w_req      = dmemREN | dmemWEN;
  assign w_match    = (r_msi[w_idx] != MSI_I) && (r_tag[w_idx] == w_tag);
  // A simultaneous load and store is handled as a store.
  assign w_rd_hit   = w_match && !dmemWEN;
  assign w_wr_hit   = w_match && dmemWEN && (r_msi[w_idx] == MSI_M);
  assign w_victim_m = (r_msi[w_idx] == MSI_M) && (r_tag[w_idx] != w_tag);
  assign w_snp_idx  = ccsnoopaddr[IDXW+1:2];
  assign w_snp_hit  = (r_msi[w_snp_idx] != MSI_I) &&
                      (r_tag[w_snp_idx] == ccsnoopaddr[31:IDXW+2]);
  assign w_sidx     = r_snp_addr[IDXW+1:2];
  assign w_fl_m     = (r_msi[r_fidx] == MSI_M);
  assign w_unused   = (^{dmemaddr[1:0], ccsnoopaddr[1:0]}) ^ (CPUID < 0);

  assign flushed = (r_state == HALTED);

  // Bus and datapath outputs are decoded from state so reset clears them at once.
  always_comb begin
    dhit     = 1'b0;
    dmemload = 32'h0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'h0;
    dstore   = 32'h0;
    cctrans  = 1'b0;
    ccwrite  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!ccwait && !halt && w_req && (w_rd_hit || w_wr_hit)) begin
          dhit     = 1'b1;
          dmemload = r_data[w_idx];
        end
      end
      WB: begin
        if (!ccwait && (r_msi[w_idx] == MSI_M)) begin
          dWEN    = 1'b1;
          cctrans = 1'b1;
          daddr   = {r_tag[w_idx], w_idx, 2'b00};
          dstore  = r_data[w_idx];
        end
      end
      FETCH: begin
        if (!ccwait) begin
          dREN    = 1'b1;
          cctrans = 1'b1;
          ccwrite = dmemWEN;
          daddr   = dmemaddr;
          if (!dwait) begin
            dhit     = 1'b1;
            dmemload = dload;
          end
        end
      end
      SNOOP_WB: begin
        ccwrite = 1'b1;
        dWEN    = 1'b1;
        daddr   = r_snp_addr;
        dstore  = r_data[w_sidx];
      end
      FLUSH: begin
        if (!ccwait && w_fl_m) begin
          dWEN    = 1'b1;
          cctrans = 1'b1;
          daddr   = {r_tag[r_fidx], r_fidx, 2'b00};
          dstore  = r_data[r_fidx];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_ret      <= IDLE;
      r_fidx     <= '0;
      r_snp_addr <= 32'h0;
      r_snp_inv  <= 1'b0;
      for (int i = 0; i < SETS; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= 32'h0;
        r_msi[i]  <= MSI_I;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (ccwait) begin
            r_ret   <= IDLE;
            r_state <= SNOOP;
          end else if (halt) begin
            r_state <= FLUSH;
          end else if (w_req) begin
            if (w_wr_hit)
              r_data[w_idx] <= dmemstore;
            else if (!w_rd_hit)
              r_state <= w_victim_m ? WB : FETCH;
          end
        end
        WB: begin
          if (ccwait) begin
            r_ret   <= WB;
            r_state <= SNOOP;
          end else if (r_msi[w_idx] != MSI_M) begin
            // A snoop already wrote the victim back while we were away.
            r_state <= FETCH;
          end else if (!dwait) begin
            r_msi[w_idx] <= MSI_I;
            r_state      <= FETCH;
          end
        end
        FETCH: begin
          if (ccwait) begin
            r_ret   <= FETCH;
            r_state <= SNOOP;
          end else if (!dwait) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= dmemWEN ? dmemstore : dload;
            r_msi[w_idx]  <= dmemWEN ? MSI_M : MSI_S;
            r_state       <= IDLE;
          end
        end
        SNOOP: begin
          r_snp_addr <= ccsnoopaddr;
          r_snp_inv  <= ccinv;
          if (w_snp_hit && (r_msi[w_snp_idx] == MSI_M)) begin
            r_state <= SNOOP_WB;
          end else begin
            if (w_snp_hit && ccinv)
              r_msi[w_snp_idx] <= MSI_I;
            r_state <= r_ret;
          end
        end
        SNOOP_WB: begin
          if (!dwait) begin
            r_msi[w_sidx] <= r_snp_inv ? MSI_I : MSI_S;
            r_state       <= r_ret;
          end
        end
        FLUSH: begin
          if (ccwait) begin
            r_ret   <= FLUSH;
            r_state <= SNOOP;
          end else if (!w_fl_m || !dwait) begin
            if (w_fl_m)
              r_msi[r_fidx] <= MSI_I;
            r_fidx <= r_fidx + IDXW'(1);
            if (r_fidx == LAST_IDX)
              r_state <= HALTED;
          end
        end
        HALTED: begin
          if (ccwait) begin
            r_ret   <= HALTED;
            r_state <= SNOOP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherent_dcache.sv
// Scoreboard bench for coherent_dcache: a latency-programmable bus responder backed by a
// word memory model, with expected load data queued per request and checked on dhit.
module tb_coherent_dcache;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic [31:0] dmemaddr = 32'h0;
  logic [31:0] dmemstore = 32'h0;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload = 32'h0;
  logic        dwait = 1'b1;
  logic        cctrans;
  logic        ccwrite;
  logic        ccwait = 1'b0;
  logic        ccinv = 1'b0;
  logic [31:0] ccsnoopaddr = 32'h0;

  coherent_dcache #(.SETS(16), .CPUID(0)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait), .cctrans(cctrans), .ccwrite(ccwrite),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
  );

  always #5 CLK = ~CLK;

  wire [101:0] w_outs = {dhit, flushed, dREN, dWEN, cctrans, ccwrite, daddr, dstore, dmemload};

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q[$];
  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];
  logic        wq_c[$];
  logic        wq_f[$];
  int   lat_g = 1;
  int   bus_cnt = 0;
  int   rd_cnt = 0;
  int   wr_at_rd = -1;
  int   acc_cycles = 0;
  bit   acc_ok = 0;
  logic ccw_rd = 0;
  logic cct_rd = 0;
  logic busy_at_snoop = 0;

  // Scoreboard: every datapath load that completes is matched against the queued value.
  always begin
    @(negedge CLK);
    #3;
    if (nRST && dhit && dmemREN && !dmemWEN) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_load: got %h, nothing expected", dmemload);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (dmemload !== e) begin
          n_err++;
          $display("FAIL sb_load_data: got %h want %h", dmemload, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Memory-side responder, called once per cycle just after the falling edge.
  task automatic bus_step();
    if (dREN || dWEN) begin
      if (bus_cnt >= lat_g) begin
        dwait   = 1'b0;
        bus_cnt = 0;
        if (dWEN) begin
          mem[daddr] = dstore;
          wq_a.push_back(daddr);
          wq_d.push_back(dstore);
          wq_c.push_back(ccwrite);
          wq_f.push_back(flushed);
        end else begin
          dload    = mem.exists(daddr) ? mem[daddr] : 32'h0;
          rd_cnt   = rd_cnt + 1;
          wr_at_rd = wq_a.size();
        end
      end else begin
        dwait   = 1'b1;
        bus_cnt = bus_cnt + 1;
      end
    end else begin
      dwait   = 1'b1;
      bus_cnt = 0;
    end
  endtask

  task automatic clear_log();
    wq_a.delete(); wq_d.delete(); wq_c.delete(); wq_f.delete();
    rd_cnt = 0; wr_at_rd = -1;
  endtask

  // mode: 0 load, 1 store, 2 load+store asserted together. snoop_at: cycle to pulse ccwait (0 = never).
  task automatic access(input int mode, input logic [31:0] addr, input logic [31:0] wd,
                        input int snoop_at, input logic [31:0] saddr);
    @(posedge CLK); #1;
    dmemREN = (mode != 1); dmemWEN = (mode != 0); dmemaddr = addr; dmemstore = wd;
    clear_log();
    acc_ok = 0; acc_cycles = 0; ccw_rd = 0; cct_rd = 0; busy_at_snoop = 1'b1;
    while (!acc_ok && acc_cycles < 60) begin
      @(negedge CLK);
      acc_cycles++;
      ccwait = (acc_cycles == snoop_at); ccsnoopaddr = saddr; ccinv = 1'b0;
      #1;
      if (ccwait) busy_at_snoop = dREN | dWEN | cctrans;
      bus_step();
      #1;
      if (dREN) begin ccw_rd = ccwrite; cct_rd = cctrans; end
      if (dhit) acc_ok = 1;
      @(posedge CLK); #1;
      ccwait = 1'b0;
    end
    dmemREN = 1'b0; dmemWEN = 1'b0; dwait = 1'b1;
  endtask

  task automatic snoop(input logic [31:0] a, input logic inv);
    clear_log();
    @(negedge CLK);
    ccwait = 1'b1; ccsnoopaddr = a; ccinv = inv;
    #1; bus_step();
    @(posedge CLK); #1;
    ccwait = 1'b0;
    repeat (6) begin
      @(negedge CLK); #1; bus_step();
      @(posedge CLK); #1;
    end
    dwait = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    n_cmp++;
    if (w_outs !== 102'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", w_outs);
    end
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_cold_read();
    lat_g = 2;
    mem[32'h40] = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    access(0, 32'h40, 32'h0, 0, 32'h0);
    n_cmp++; if (!acc_ok) begin n_err++; $display("FAIL cold_done: got timeout want dhit"); end
    n_cmp++; if (rd_cnt !== 1) begin n_err++; $display("FAIL cold_bus_reads: got %0d want 1", rd_cnt); end
    n_cmp++; if ({cct_rd, ccw_rd} !== 2'b10) begin
      n_err++; $display("FAIL cold_cc_signals: got cctrans,ccwrite=%b want 10", {cct_rd, ccw_rd});
    end
    exp_q.push_back(32'hDEADBEEF);
    access(0, 32'h40, 32'h0, 0, 32'h0);
    n_cmp++; if (acc_cycles !== 1 || rd_cnt !== 0) begin
      n_err++; $display("FAIL reread_hit: got cycles=%0d reads=%0d want 1/0", acc_cycles, rd_cnt);
    end
  endtask

  task automatic test_write_upgrade();
    lat_g = 1;
    access(1, 32'h40, 32'h1234, 0, 32'h0);
    n_cmp++; if (rd_cnt !== 1 || ccw_rd !== 1'b1) begin
      n_err++; $display("FAIL upgrade_fetch: got reads=%0d ccwrite=%b want 1/1", rd_cnt, ccw_rd);
    end
    exp_q.push_back(32'h1234);
    access(0, 32'h40, 32'h0, 0, 32'h0);
    n_cmp++; if (rd_cnt !== 0 || acc_cycles !== 1) begin
      n_err++; $display("FAIL upgrade_reread: got reads=%0d cycles=%0d want 0/1", rd_cnt, acc_cycles);
    end
  endtask

  task automatic test_evict();
    lat_g = 1;
    mem[32'h80] = 32'hCAFE0080;
    exp_q.push_back(32'hCAFE0080);
    access(0, 32'h80, 32'h0, 0, 32'h0);
    n_cmp++; if (wq_a.size() !== 1 || wr_at_rd !== 1) begin
      n_err++; $display("FAIL evict_order: got writes=%0d writes_before_read=%0d want 1/1", wq_a.size(), wr_at_rd);
    end
    if (wq_a.size() > 0) begin
      n_cmp++; if (wq_a[0] !== 32'h40 || wq_d[0] !== 32'h1234) begin
        n_err++; $display("FAIL evict_wb: got %h<-%h want 00000040<-00001234", wq_a[0], wq_d[0]);
      end
    end
    exp_q.push_back(32'h1234);
    access(0, 32'h40, 32'h0, 0, 32'h0);
    n_cmp++; if (rd_cnt !== 1 || wq_a.size() !== 0) begin
      n_err++; $display("FAIL evict_victim_invalid: got reads=%0d writes=%0d want 1/0", rd_cnt, wq_a.size());
    end
  endtask

  task automatic test_snoop();
    lat_g = 1;
    access(1, 32'h40, 32'h5555, 0, 32'h0);
    snoop(32'h80, 1'b1);
    n_cmp++; if (wq_a.size() !== 0) begin
      n_err++; $display("FAIL snoop_other_tag: got writes=%0d want 0", wq_a.size());
    end
    exp_q.push_back(32'h5555);
    access(0, 32'h40, 32'h0, 0, 32'h0);
    n_cmp++; if (rd_cnt !== 0) begin n_err++; $display("FAIL snoop_other_keep: got reads=%0d want 0", rd_cnt); end
    snoop(32'h40, 1'b1);
    n_cmp++; if (wq_a.size() !== 1 || (wq_a.size() == 1 && {wq_a[0], wq_d[0], wq_c[0]} !== {32'h40, 32'h5555, 1'b1})) begin
      n_err++; $display("FAIL snoop_inv_wb: got n=%0d a=%h d=%h want 1 00000040 00005555", wq_a.size(),
                        (wq_a.size() > 0) ? wq_a[0] : 32'h0, (wq_d.size() > 0) ? wq_d[0] : 32'h0);
    end
    exp_q.push_back(32'h5555);
    access(0, 32'h40, 32'h0, 0, 32'h0);
    n_cmp++; if (rd_cnt !== 1) begin n_err++; $display("FAIL snoop_inv_state: got reads=%0d want 1", rd_cnt); end
    access(1, 32'h40, 32'h6666, 0, 32'h0);
    snoop(32'h40, 1'b0);
    n_cmp++; if (wq_d.size() !== 1 || (wq_d.size() == 1 && wq_d[0] !== 32'h6666)) begin
      n_err++; $display("FAIL snoop_shr_wb: got n=%0d want 1 write of 00006666", wq_d.size());
    end
    exp_q.push_back(32'h6666);
    access(0, 32'h40, 32'h0, 0, 32'h0);
    n_cmp++; if (rd_cnt !== 0) begin n_err++; $display("FAIL snoop_shr_read: got reads=%0d want 0", rd_cnt); end
    access(1, 32'h40, 32'h7777, 0, 32'h0);
    n_cmp++; if (rd_cnt !== 1 || ccw_rd !== 1'b1) begin
      n_err++; $display("FAIL snoop_shr_state: got reads=%0d ccwrite=%b want 1/1", rd_cnt, ccw_rd);
    end
  endtask

  task automatic test_snoop_during_fetch();
    lat_g = 3;
    mem[32'h104] = 32'h0BAD0104;
    exp_q.push_back(32'h0BAD0104);
    access(0, 32'h104, 32'h0, 3, 32'h48);
    n_cmp++; if (!acc_ok || rd_cnt !== 1) begin
      n_err++; $display("FAIL fetch_reissue: got done=%0d reads=%0d want 1/1", acc_ok, rd_cnt);
    end
    n_cmp++; if (busy_at_snoop !== 1'b0) begin
      n_err++; $display("FAIL fetch_drop_on_snoop: got bus_busy=%b want 0", busy_at_snoop);
    end
  endtask

  task automatic test_flush();
    lat_g = 1;
    snoop(32'h40, 1'b0);
    access(1, 32'h0C, 32'h33, 0, 32'h0);
    access(1, 32'h3C, 32'hFF, 0, 32'h0);
    clear_log();
    @(posedge CLK); #1; halt = 1'b1;
    for (int c = 0; c < 100 && !flushed; c++) begin
      @(negedge CLK); #1; bus_step(); #1;
    end
    n_cmp++; if (flushed !== 1'b1) begin n_err++; $display("FAIL flush_done: got flushed=%b want 1", flushed); end
    n_cmp++; if (wq_a.size() !== 2) begin n_err++; $display("FAIL flush_count: got %0d writes want 2", wq_a.size()); end
    if (wq_a.size() == 2) begin
      n_cmp++; if ({wq_a[0], wq_d[0], wq_a[1], wq_d[1]} !== {32'h0C, 32'h33, 32'h3C, 32'hFF}) begin
        n_err++; $display("FAIL flush_order: got %h<-%h %h<-%h want 0000000c<-00000033 0000003c<-000000ff",
                          wq_a[0], wq_d[0], wq_a[1], wq_d[1]);
      end
      n_cmp++; if (wq_f[1] !== 1'b0) begin n_err++; $display("FAIL flush_early: got flushed=%b during last wb want 0", wq_f[1]); end
    end
    repeat (5) @(negedge CLK);
    n_cmp++; if (flushed !== 1'b1) begin n_err++; $display("FAIL flush_sticky: got %b want 1", flushed); end
    nRST = 1'b0; halt = 1'b0; #1;
    n_cmp++; if (w_outs !== 102'h0) begin n_err++; $display("FAIL flush_reset: got %h want 0", w_outs); end
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_reset_mid_flush();
    bit seen;
    lat_g = 1;
    access(1, 32'h3C, 32'h77, 0, 32'h0);
    @(posedge CLK); #1; halt = 1'b1; dwait = 1'b1;
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge CLK); #1;
      if (dWEN) seen = 1;
    end
    n_cmp++; if (!seen || daddr !== 32'h3C) begin
      n_err++; $display("FAIL midflush_wb: got seen=%0d daddr=%h want 1 0000003c", seen, daddr);
    end
    nRST = 1'b0; #1;
    n_cmp++; if (w_outs !== 102'h0) begin n_err++; $display("FAIL midflush_reset: got %h want 0", w_outs); end
    halt = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    exp_q.push_back(32'hFF);
    access(0, 32'h3C, 32'h0, 0, 32'h0);
    n_cmp++; if (rd_cnt !== 1) begin n_err++; $display("FAIL midflush_lines_invalid: got reads=%0d want 1", rd_cnt); end
  endtask

  task automatic test_ren_wen();
    lat_g = 1;
    access(2, 32'h14, 32'hAB, 0, 32'h0);
    n_cmp++; if (ccw_rd !== 1'b1) begin n_err++; $display("FAIL renwen_is_write: got ccwrite=%b want 1", ccw_rd); end
    exp_q.push_back(32'hAB);
    access(0, 32'h14, 32'h0, 0, 32'h0);
    n_cmp++; if (rd_cnt !== 0) begin n_err++; $display("FAIL renwen_data: got reads=%0d want 0", rd_cnt); end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_upgrade();
    test_evict();
    test_snoop();
    test_snoop_during_fetch();
    test_flush();
    test_reset_mid_flush();
    test_ren_wen();
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_leftover: got %0d pending loads want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
